// File: rtl/odo_tx_scheduler_if.sv
// Odometer scheduler signal bundle: UART rx bytes, encoder count, UART tx handshake, status.
// The master side drives the inputs (host/UART/encoder); the slave is the scheduler.
interface odo_tx_scheduler_if;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic [15:0] count_in;
   logic        tx_busy;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        count_latch;
   logic [7:0]  period;
   logic [7:0]  overrun;

   modport master (
      output rx_byte, rx_valid, count_in, tx_busy,
      input  tx_data, tx_start, count_latch, period, overrun
   );

   modport slave (
      input  rx_byte, rx_valid, count_in, tx_busy,
      output tx_data, tx_start, count_latch, period, overrun
   );
endinterface

// File: rtl/odo_tx_scheduler.sv
// Encoder report scheduler: 0xA5 P sets the period, 0x5A forces a report; frames are HDR,cnt_hi,cnt_lo,seq,xor.
// Trigger to count_latch 1 cycle, count_latch to first tx_start 1 cycle; bytes wait for tx_busy low, one trigger is queued.
module odo_tx_scheduler #(
   parameter int         TICK_DIV = 1000,
   parameter logic [7:0] HDR      = 8'h55
) (
   input logic               CLK,
   input logic               RST,
   odo_tx_scheduler_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LATCH, SEND, WAIT_HI, WAIT_LO} state_t;

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   state_t        state_q, state_d;
   logic          arm_q, arm_d;
   logic [7:0]    period_q, period_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    pcnt_q, pcnt_d;
   logic          pend_q, pend_d;
   logic [7:0]    overrun_q, overrun_d;
   logic [7:0]    seq_q, seq_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_start_q, tx_start_d;
   logic          count_latch_q, count_latch_d;
   logic          cmd_trig, period_wr, tick, per_trig, trig;

   function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [15:0] c,
                                              input logic [7:0] s);
      case (i)
         3'd0:    frame_byte = HDR;
         3'd1:    frame_byte = c[15:8];
         3'd2:    frame_byte = c[7:0];
         3'd3:    frame_byte = s;
         default: frame_byte = HDR ^ c[15:8] ^ c[7:0] ^ s;
      endcase
   endfunction

   always_comb begin
      state_d       = state_q;
      arm_d         = arm_q;
      period_d      = period_q;
      presc_d       = presc_q;
      pcnt_d        = pcnt_q;
      pend_d        = pend_q;
      overrun_d     = overrun_q;
      seq_d         = seq_q;
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      tx_data_d     = tx_data_q;
      tx_start_d    = 1'b0;
      count_latch_d = 1'b0;
      cmd_trig      = 1'b0;
      period_wr     = 1'b0;

      // Byte after 0xA5 is always the period, whatever its value.
      if (bus.rx_valid) begin
         if (arm_q) begin
            period_d  = bus.rx_byte;
            arm_d     = 1'b0;
            period_wr = 1'b1;
         end else if (bus.rx_byte == 8'hA5) begin
            arm_d = 1'b1;
         end else if (bus.rx_byte == 8'h5A) begin
            cmd_trig = 1'b1;
         end
      end

      tick     = (period_q != 8'd0) && (presc_q == PW'(TICK_DIV - 1));
      per_trig = tick && (pcnt_q == period_q - 8'd1);
      if (period_q != 8'd0) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick) pcnt_d = per_trig ? 8'd0 : pcnt_q + 8'd1;
      end
      if (period_wr) begin
         presc_d = '0;
         pcnt_d  = 8'd0;
      end
      trig = cmd_trig | per_trig;

      case (state_q)
         IDLE: begin
            if (trig || pend_q) begin
               state_d       = LATCH;
               count_latch_d = 1'b1;
               pend_d        = trig && pend_q;
            end
         end
         LATCH: begin
            cnt_d      = bus.count_in;
            idx_d      = 3'd0;
            tx_data_d  = HDR;
            tx_start_d = !bus.tx_busy;
            state_d    = SEND;
         end
         SEND: begin
            // tx_start is registered, so the pulse lands one cycle after tx_busy is seen low.
            if (tx_start_q) state_d = WAIT_HI;
            else            tx_start_d = !bus.tx_busy;
         end
         WAIT_HI: begin
            if (bus.tx_busy) state_d = WAIT_LO;
         end
         WAIT_LO: begin
            if (!bus.tx_busy) begin
               if (idx_q == 3'd4) begin
                  state_d = IDLE;
                  seq_d   = seq_q + 8'd1;
               end else begin
                  idx_d      = idx_q + 3'd1;
                  tx_data_d  = frame_byte(idx_q + 3'd1, cnt_q, seq_q);
                  tx_start_d = 1'b1;
                  state_d    = SEND;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE && trig) begin
         if (!pend_q)                  pend_d    = 1'b1;
         else if (overrun_q != 8'hFF)  overrun_d = overrun_q + 8'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= IDLE;
         arm_q         <= 1'b0;
         period_q      <= 8'd0;
         presc_q       <= '0;
         pcnt_q        <= 8'd0;
         pend_q        <= 1'b0;
         overrun_q     <= 8'd0;
         seq_q         <= 8'd0;
         cnt_q         <= 16'd0;
         idx_q         <= 3'd0;
         tx_data_q     <= 8'd0;
         tx_start_q    <= 1'b0;
         count_latch_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         arm_q         <= arm_d;
         period_q      <= period_d;
         presc_q       <= presc_d;
         pcnt_q        <= pcnt_d;
         pend_q        <= pend_d;
         overrun_q     <= overrun_d;
         seq_q         <= seq_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         tx_data_q     <= tx_data_d;
         tx_start_q    <= tx_start_d;
         count_latch_q <= count_latch_d;
      end
   end

   assign bus.tx_data     = tx_data_q;
   assign bus.tx_start    = tx_start_q;
   assign bus.count_latch = count_latch_q;
   assign bus.period      = period_q;
   assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_odo_tx_scheduler.sv
// Randomised bench for odo_tx_scheduler against a frame-level reference model, plus fixed scenarios
// whose literal expectations pin both the model and the design.
module tb_odo_tx_scheduler;
   localparam int TD = 4;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   odo_tx_scheduler_if bus();

   odo_tx_scheduler #(.TICK_DIV(TD), .HDR(8'h55)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

   always #5 CLK = ~CLK;

   int n_chk = 0, n_pass = 0, cyc = 0;
   int uart_len = 10, uart_cnt = 0;
   bit force_busy = 0, last_start = 0;
   logic [7:0] got[$];
   int lat_cyc[$];
   int n_start = 0;

   // Reference model state: what has been commanded and where the current frame stands.
   bit         m_arm, m_in_frame, m_lat, m_start, m_due, m_inflight, m_seen_hi, m_pend;
   logic [7:0] m_period, m_ovr, m_seq;
   int         m_c, m_sent;
   logic [7:0] exp_frame[5];
   bit         e_latch, e_start;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
   endtask

   task automatic model_reset();
      m_arm = 0; m_in_frame = 0; m_lat = 0; m_start = 0; m_due = 0; m_inflight = 0;
      m_seen_hi = 0; m_pend = 0; m_period = 0; m_ovr = 0; m_seq = 0; m_c = 0; m_sent = 0;
      e_latch = 0; e_start = 0;
   endtask

   task automatic model_edge();
      bit cmd, per, trig, was;
      if (RST) begin
         model_reset();
         return;
      end
      cmd = 0;
      per = (m_period != 0) && (((m_c + 1) % (TD * int'(m_period))) == 0);
      m_c++;
      if (bus.rx_valid) begin
         if (m_arm) begin
            m_period = bus.rx_byte; m_arm = 0; m_c = 0;
         end else if (bus.rx_byte == 8'hA5) m_arm = 1;
         else if (bus.rx_byte == 8'h5A) cmd = 1;
      end
      trig = cmd | per;
      was = m_in_frame;
      e_latch = 0;
      e_start = 0;
      if (m_lat) begin
         exp_frame[0] = 8'h55;
         exp_frame[1] = bus.count_in[15:8];
         exp_frame[2] = bus.count_in[7:0];
         exp_frame[3] = m_seq;
         exp_frame[4] = 8'h55 ^ bus.count_in[15:8] ^ bus.count_in[7:0] ^ m_seq;
         m_sent = 0;
         m_due = 1;
      end
      if (m_start) begin
         m_inflight = 1; m_seen_hi = 0;
      end else if (m_inflight) begin
         if (!m_seen_hi) m_seen_hi = bus.tx_busy;
         else if (!bus.tx_busy) begin
            m_inflight = 0;
            m_sent++;
            if (m_sent == 5) begin m_in_frame = 0; m_seq++; end
            else m_due = 1;
         end
      end
      if (m_due && !bus.tx_busy) begin e_start = 1; m_due = 0; end
      if (!was) begin
         if (trig || m_pend) begin e_latch = 1; m_in_frame = 1; m_pend = trig && m_pend; end
      end else if (trig) begin
         if (!m_pend) m_pend = 1;
         else if (m_ovr != 8'hFF) m_ovr++;
      end
      m_lat = e_latch;
      m_start = e_start;
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
      if (last_start) uart_cnt = uart_len;
      else if (uart_cnt > 0) uart_cnt--;
      bus.tx_busy = force_busy || (uart_cnt > 0);
      @(negedge CLK);
      cyc++;
      chk("count_latch", bus.count_latch, e_latch);
      chk("tx_start", bus.tx_start, e_start);
      chk("period", bus.period, m_period);
      chk("overrun", bus.overrun, m_ovr);
      chk("no_back_to_back", last_start & bus.tx_start, 0);
      if (bus.tx_start === 1'b1 && e_start) chk("tx_data", bus.tx_data, exp_frame[m_sent]);
      if (RST) chk("tx_data_reset", bus.tx_data, 0);
      if (bus.tx_start === 1'b1) begin got.push_back(bus.tx_data); n_start++; end
      if (bus.count_latch === 1'b1) lat_cyc.push_back(cyc);
      last_start = (bus.tx_start === 1'b1);
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_byte = b;
      bus.rx_valid = 1'b1;
      step();
      bus.rx_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] f33[5];
      logic [7:0] f36[5];
      int n0, s0, wcyc, r;
      bit reached;
      f33 = '{8'h55, 8'h12, 8'h34, 8'h00, 8'h73};
      f36 = '{8'h55, 8'hFF, 8'hFE, 8'h01, 8'h55};
      bus.rx_byte = 0; bus.rx_valid = 0; bus.count_in = 0; bus.tx_busy = 0;
      model_reset();
      repeat (3) step();
      chk("reset_period", bus.period, 0);
      chk("reset_overrun", bus.overrun, 0);
      RST = 1'b0;

      // Single report of 0x1234 with a 10-cycle UART
      bus.count_in = 16'h1234;
      got.delete();
      send_byte(8'h5A);
      repeat (90) step();
      chk("frame1234_len", got.size(), 5);
      for (int i = 0; i < 5 && i < got.size(); i++) chk("frame1234_byte", got[i], f33[i]);

      // Negative count, second frame carries seq 1
      bus.count_in = 16'hFFFE;
      got.delete();
      send_byte(8'h5A);
      repeat (90) step();
      chk("framefffe_len", got.size(), 5);
      for (int i = 0; i < 5 && i < got.size(); i++) chk("framefffe_byte", got[i], f36[i]);

      // Two extra triggers during a frame: one queued, one dropped
      bus.count_in = 16'h0A0B;
      n0 = lat_cyc.size();
      send_byte(8'h5A);
      repeat (20) step();
      send_byte(8'h5A);
      repeat (10) step();
      send_byte(8'h5A);
      repeat (170) step();
      chk("queued_frames", lat_cyc.size() - n0, 2);
      chk("overrun_one", bus.overrun, 1);

      // Periodic reporting
      uart_len = 3;
      send_byte(8'hA5);
      send_byte(8'h03);
      wcyc = cyc;
      repeat (12) step();
      chk("period3_first_latch", (lat_cyc.size() > 0) ? lat_cyc[lat_cyc.size()-1] - wcyc : -1, 12);
      send_byte(8'hA5);
      send_byte(8'h0A);
      repeat (200) step();
      chk("period10_interval", (lat_cyc.size() > 1) ?
          lat_cyc[lat_cyc.size()-1] - lat_cyc[lat_cyc.size()-2] : -1, 40);
      send_byte(8'hA5);
      send_byte(8'h00);
      repeat (40) step();
      n0 = lat_cyc.size();
      repeat (200) step();
      chk("period0_stopped", lat_cyc.size() - n0, 0);

      // Reset while byte 3 is on the wire
      uart_len = 10;
      s0 = n_start;
      send_byte(8'h5A);
      reached = 0;
      for (int i = 0; i < 200 && !reached; i++) begin
         if (n_start - s0 >= 4) reached = 1;
         else step();
      end
      chk("reached_byte3", reached, 1);
      RST = 1'b1;
      step();
      chk("midrst_tx_start", bus.tx_start, 0);
      chk("midrst_count_latch", bus.count_latch, 0);
      chk("midrst_tx_data", bus.tx_data, 0);
      chk("midrst_period", bus.period, 0);
      chk("midrst_overrun", bus.overrun, 0);
      step();
      RST = 1'b0;
      s0 = n_start;
      repeat (60) step();
      chk("after_rst_quiet", n_start - s0, 0);
      bus.count_in = 16'h0102;
      got.delete();
      send_byte(8'h5A);
      repeat (90) step();
      chk("after_rst_len", got.size(), 5);
      chk("after_rst_seq", (got.size() > 3) ? got[3] : 8'hEE, 0);

      // Transmitter busy at frame start
      force_busy = 1;
      s0 = n_start;
      send_byte(8'h5A);
      repeat (20) step();
      chk("held_busy_no_start", n_start - s0, 0);
      force_busy = 0;
      repeat (3) step();
      chk("held_busy_one_start", n_start - s0, 1);
      repeat (90) step();

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) RST = 1'b1;
         else RST = 1'b0;
         if ($urandom_range(0, 15) == 0) bus.count_in = 16'($urandom);
         if ($urandom_range(0, 63) == 0) uart_len = $urandom_range(1, 12);
         if ($urandom_range(0, 7) == 0) begin
            r = $urandom_range(0, 9);
            if (r <= 3)      send_byte(8'h5A);
            else if (r <= 5) send_byte(8'hA5);
            else if (r <= 8) send_byte(8'($urandom_range(0, 6)));
            else             send_byte(8'($urandom));
         end else begin
            step();
         end
      end
      RST = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
